// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from 4 requesters into a single UART transmitter.
// Latency: req sampled at edge N -> grant/tx_start pulse during cycle N+1; all outputs registered.
// Backpressure: no arbitration while tx_busy=1; optional start timeout under UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic [1:0]             cur_id,
  output logic                   arb_busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           cur_id_q, cur_id_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 tx_start_q, tx_start_d;
  logic                 arb_busy_q, arb_busy_d;

  logic                 win_vld;
  logic [1:0]           win_id;
  logic [1:0]           cand;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 timeout_err_q, timeout_err_d;
`endif

  // Round-robin winner search starting one past the last granted index.
  always_comb begin
    win_vld = 1'b0;
    win_id  = ptr_q;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_id_d   = cur_id_q;
    tx_data_d  = tx_data_q;
    grant_d    = '0;
    tx_start_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld && !tx_busy) begin
          state_d    = START;
          cur_id_d   = win_id;
          tx_data_d  = req_data[{win_id, 3'b000} +: 8];
          grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
          tx_start_d = 1'b1;
        end
      end
      START: begin
        // Pointer moves only once the grant has actually been issued.
        state_d = WAIT_HI;
        ptr_d   = cur_id_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT_HI: begin
`ifdef UART_ARB_TIMEOUT_EN
        if (tx_busy) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        if (tx_busy) state_d = WAIT_LO;
`endif
      end
      WAIT_LO: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    arb_busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd3;
      cur_id_q   <= 2'd0;
      tx_data_q  <= 8'h00;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      arb_busy_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cur_id_q   <= cur_id_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      arb_busy_q <= arb_busy_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign cur_id   = cur_id_q;
  assign arb_busy = arb_busy_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
